// File: rtl/qq_op_sched.sv
// Operation scheduler for the Quick Priority Queue: handshakes, occupancy,
// and the post-removal fill-counter clear / fill sequence.
module qq_op_sched #(
  parameter  int DEPTH       = 16,
  parameter  int FILL_CYCLES = 3,
  localparam int CW          = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          enq_valid,
  output logic          enq_ready,
  input  logic          deq_valid,
  output logic          deq_ready,
  output logic          q_enq,
  output logic          q_deq,
  output logic          q_flush,
  output logic          q_fill_rst,
  output logic          q_fill,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          busy
);

  localparam int FW = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;
  localparam logic [FW-1:0] FC_LAST = FW'(FILL_CYCLES-1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, CLR, FILL} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [FW-1:0] fc_q, fc_d;
  logic          q_enq_q, q_enq_d;
  logic          q_deq_q, q_deq_d;
  logic          q_flush_q, q_flush_d;
  logic          q_fill_rst_q, q_fill_rst_d;
  logic          q_fill_q, q_fill_d;
  logic          idle;
  logic          enq_acc, deq_acc;

  assign idle  = (state_q == IDLE);
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign busy  = !idle;

  // a replace at full is allowed because the dequeue frees the slot
  assign deq_ready = idle && !flush && !empty;
  assign enq_ready = idle && !flush &&
                     (!full || (deq_valid && !empty));

  assign enq_acc = enq_valid && enq_ready;
  assign deq_acc = deq_valid && deq_ready;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    fc_d         = fc_q;
    q_enq_d      = 1'b0;
    q_deq_d      = 1'b0;
    q_flush_d    = 1'b0;
    q_fill_rst_d = 1'b0;
    q_fill_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush) begin
          count_d   = '0;
          q_flush_d = 1'b1;
        end else begin
          q_enq_d      = enq_acc;
          q_deq_d      = deq_acc;
          q_fill_rst_d = deq_acc;
          count_d      = count_q + CW'(enq_acc)
                                 - CW'(deq_acc);
          if (deq_acc) state_d = CLR;
        end
      end
      CLR: begin
        fc_d     = '0;
        state_d  = FILL;
        q_fill_d = 1'b1;
      end
      FILL: begin
        if (fc_q == FC_LAST) begin
          fc_d    = '0;
          state_d = IDLE;
        end else begin
          fc_d     = fc_q + FW'(1);
          q_fill_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush && !idle) begin
      state_d   = IDLE;
      count_d   = '0;
      fc_d      = '0;
      q_flush_d = 1'b1;
      q_fill_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      fc_q         <= '0;
      q_enq_q      <= 1'b0;
      q_deq_q      <= 1'b0;
      q_flush_q    <= 1'b0;
      q_fill_rst_q <= 1'b0;
      q_fill_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      fc_q         <= fc_d;
      q_enq_q      <= q_enq_d;
      q_deq_q      <= q_deq_d;
      q_flush_q    <= q_flush_d;
      q_fill_rst_q <= q_fill_rst_d;
      q_fill_q     <= q_fill_d;
    end
  end

  assign count      = count_q;
  assign q_enq      = q_enq_q;
  assign q_deq      = q_deq_q;
  assign q_flush    = q_flush_q;
  assign q_fill_rst = q_fill_rst_q;
  assign q_fill     = q_fill_q;

endmodule

// File: tb/tb_qq_op_sched.sv
// Bench for qq_op_sched: directed steps plus random traffic,
// compared each cycle against a time-window reference model.
module tb_qq_op_sched;

  localparam int D  = 4;
  localparam int FC = 3;
  localparam int CW = $clog2(D+1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush, enq_valid, deq_valid;
  logic          enq_ready, deq_ready;
  logic          q_enq, q_deq, q_flush;
  logic          q_fill_rst, q_fill;
  logic [CW-1:0] count;
  logic          full, empty, busy;

  int checks = 0;
  int errors = 0;

  qq_op_sched #(.DEPTH(D), .FILL_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .q_enq(q_enq), .q_deq(q_deq), .q_flush(q_flush),
    .q_fill_rst(q_fill_rst), .q_fill(q_fill),
    .count(count), .full(full), .empty(empty),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // model: occupancy, the last accepted dequeue cycle,
  // and the command pulses due this cycle
  int cyc;
  int t_hs;
  int m_cnt;
  bit p_enq, p_deq, p_flush;

  function automatic bit m_busy();
    return (cyc >= t_hs+1) && (cyc <= t_hs+1+FC);
  endfunction

  function automatic bit m_deq_rdy();
    return !m_busy() && !flush && (m_cnt > 0);
  endfunction

  function automatic bit m_enq_rdy();
    return !m_busy() && !flush &&
      ((m_cnt < D) || (deq_valid && m_cnt > 0));
  endfunction

  task automatic model_reset();
    t_hs = -100; m_cnt = 0;
    p_enq = 0; p_deq = 0; p_flush = 0;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".q_enq"}, 32'(q_enq), 32'(p_enq));
    chk({tag, ".q_deq"}, 32'(q_deq), 32'(p_deq));
    chk({tag, ".q_flush"}, 32'(q_flush), 32'(p_flush));
    chk({tag, ".q_fill_rst"}, 32'(q_fill_rst),
        32'(cyc == t_hs+1));
    chk({tag, ".q_fill"}, 32'(q_fill),
        32'((cyc >= t_hs+2) && (cyc <= t_hs+1+FC)));
    chk({tag, ".count"}, 32'(count), 32'(m_cnt));
    chk({tag, ".full"}, 32'(full), 32'(m_cnt == D));
    chk({tag, ".empty"}, 32'(empty), 32'(m_cnt == 0));
    chk({tag, ".busy"}, 32'(busy), 32'(m_busy()));
    chk({tag, ".enq_ready"}, 32'(enq_ready),
        32'(m_enq_rdy()));
    chk({tag, ".deq_ready"}, 32'(deq_ready),
        32'(m_deq_rdy()));
  endtask

  task automatic step(input string tag, input bit f,
                      input bit e, input bit d);
    bit ea, da;
    flush = f; enq_valid = e; deq_valid = d;
    #1;
    check_outputs(tag);
    ea = e && m_enq_rdy();
    da = d && m_deq_rdy();
    p_enq = ea; p_deq = da; p_flush = f;
    if (f) begin
      m_cnt = 0; t_hs = -100;
    end else begin
      m_cnt = m_cnt + int'(ea) - int'(da);
      if (da) t_hs = cyc;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0;
    rst_n = 1'b0; flush = 0;
    enq_valid = 0; deq_valid = 0;
    model_reset();
    #3;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) step("enq_fill", 0, 1, 0);
    chk("full_after_enq", 32'(full), 32'd1);
    chk("count_after_enq", 32'(count), 32'd4);

    for (int i = 0; i < 10; i++) step("deq_to2", 0, 0, 1);
    step("deq_single", 0, 0, 1);
    for (int i = 0; i < 5; i++) step("deq_wait", 0, 0, 0);
    chk("count_after_deq", 32'(count), 32'd1);

    for (int i = 0; i < 3; i++) step("enq_top", 0, 1, 0);
    step("replace", 0, 1, 1);
    for (int i = 0; i < 5; i++) step("repl_wait", 0, 0, 0);
    chk("count_after_repl", 32'(count), 32'd4);

    step("flush_idle", 1, 0, 0);
    step("empty_both", 0, 1, 1);
    step("deq_next", 0, 0, 1);
    for (int i = 0; i < 5; i++) step("eb_wait", 0, 0, 0);

    for (int i = 0; i < 2; i++) step("pre_abort", 0, 1, 0);
    step("abort_deq", 0, 0, 1);
    step("abort_clr", 0, 0, 0);
    step("abort_f0", 0, 0, 0);
    step("abort_flush", 1, 1, 1);
    step("abort_after", 0, 0, 0);

    for (int i = 0; i < 2; i++) step("pre_rst", 0, 1, 0);
    step("rst_deq", 0, 0, 1);
    step("rst_clr", 0, 0, 0);
    step("rst_f0", 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("rst_mid_fill");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 0, 0, 0);

    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 19) == 0),
           1'($urandom), 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qq_op_sched.md
# qq_op_sched

Operation scheduler for the Quick Priority Queue. It takes enqueue and dequeue requests over valid/ready handshakes and tracks occupancy. It issues one-cycle insert/remove commands to the queue datapath. After every removal it runs the datapath refill sequence: a fill-counter clear pulse, then a fixed number of fill cycles, during which no new operation is accepted.

## Interface
- DEPTH, 16: queue capacity in entries (≥2).
- FILL_CYCLES, 3: fill cycles required after a removal (≥1).
- CW (localparam), $clog2(DEPTH+1): occupancy width.

- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of queue contents; highest priority.
- enq_valid  in  1  enqueue request.
- enq_ready  out  1  enqueue accepted when enq_valid && enq_ready.
- deq_valid  in  1  dequeue request.
- deq_ready  out  1  dequeue accepted when deq_valid && deq_ready.
- q_enq  out  1  registered pulse: insert into datapath.
- q_deq  out  1  registered pulse: remove head from datapath.
- q_flush  out  1  registered pulse: clear datapath.
- q_fill_rst  out  1  registered pulse: clear datapath fill counter.
- q_fill  out  1  registered level: datapath fill step enable.
- count  out  CW  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, CLR, FILL. An internal fill counter fc counts 0..FILL_CYCLES-1.
- IDLE, flush=1:
  - count<=0, q_flush=1 next cycle.
  - Both readies are low; no handshake occurs.
  - State stays IDLE.
- IDLE readies (flush=0):
  - deq_ready = !empty.
  - enq_ready = !full || (deq_valid && !empty). A replace is allowed at full.
- IDLE accepted operations:
  - Enq only: q_enq next cycle, count+1, stay IDLE.
  - Deq only: q_deq and q_fill_rst next cycle, count-1, go to CLR.
  - Enq and deq together (replace): q_enq, q_deq and q_fill_rst next cycle, count unchanged, go to CLR.
  - Empty with both valid: only the enqueue is accepted. The dequeue waits for a later IDLE cycle.
- CLR: lasts 1 cycle. fc<=0, go to FILL.
- FILL:
  - q_fill=1 every cycle in this state.
  - fc increments each cycle.
  - When fc==FILL_CYCLES-1, go to IDLE.
- CLR/FILL: both readies are low. flush=1 aborts to IDLE with count<=0, q_flush pulse, and q_fill deasserted on the next cycle.
- Invariants:
  - count never exceeds DEPTH and never underflows. Readies enforce this; no error path is needed.
  - q_enq and q_flush are never high together. q_fill is never high in the same cycle as q_fill_rst.

## Timing
- Reset (rst_n=0, asynchronous):
  - State is IDLE; count=0; fc=0.
  - q_enq, q_deq, q_flush, q_fill_rst, q_fill, busy and full are 0.
  - empty=1, enq_ready=1, deq_ready=0.
  - Reset during CLR/FILL abandons the sequence immediately.
- Readies, full, empty and busy are combinational from the state, count, flush and deq_valid. The handshake is evaluated in the same cycle.
- Handshake at cycle T:
  - Command pulse and count update are visible at T+1.
  - For a deq/replace, q_fill_rst is at T+1 (state CLR) and q_fill spans T+2..T+1+FILL_CYCLES. The state is IDLE again and the readies can rise at T+2+FILL_CYCLES.
- Throughput:
  - Enqueues: one per cycle.
  - Dequeues/replaces: one per FILL_CYCLES+2 cycles.
- Width rule: count arithmetic is unsigned CW bits; DEPTH+1 values are representable.

## Test plan
(DEPTH=4, FILL_CYCLES=3)
- Reset, then hold enq_valid for 6 cycles:
  - q_enq is high on 4 consecutive cycles; count goes 1,2,3,4.
  - full=1 and enq_ready=0 afterwards; no further q_enq.
- With count=2, single deq at T:
  - q_deq and q_fill_rst at T+1; q_fill at T+2..T+4; busy over T+1..T+4.
  - deq_ready is low until T+5; count=1.
- Full (count=4), enq_valid and deq_valid together:
  - Replace is accepted: q_enq and q_deq at T+1, count stays 4.
  - Fill sequence runs as above.
- Empty, enq_valid and deq_valid together:
  - Only the enqueue is accepted (count=1, no q_deq).
  - The dequeue is accepted the next cycle, followed by its fill sequence.
- Fill aborts:
  - flush during FILL (second fill cycle): q_flush next cycle, q_fill drops, count=0, IDLE, enq_ready=1.
  - Repeat with rst_n low mid-FILL: all outputs take their reset values immediately.
